// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - issue, producer and register-file write bundle for the writeback scheduler
interface regfile_wb_scheduler_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
);
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            issue_ready;
  logic [AW-1:0]   rs1_sel;
  logic [AW-1:0]   rs2_sel;
  logic            rs_hazard;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [NREG-1:0] busy;

  modport master (
    output issue_valid, issue_rd, rs1_sel, rs2_sel,
           alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  issue_ready, rs_hazard, alu_ready, lsu_ready,
           wr_en, wr_addr, wr_data, busy
  );

  modport slave (
    input  issue_valid, issue_rd, rs1_sel, rs2_sel,
           alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output issue_ready, rs_hazard, alu_ready, lsu_ready,
           wr_en, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - round-robin ALU/LSU writeback arbiter with pending-write scoreboard
module regfile_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_scheduler_if.slave  bus
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_t;

  src_t            rr_last;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [XLEN-1:0] wr_data_q;
  logic            alu_ready;
  logic            lsu_ready;
  logic            alu_xfer;
  logic            lsu_xfer;
  logic            issue_ready;
  logic            issue_xfer;

  // Readies depend only on the valids and rr_last, so at most one is ever high.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (bus.alu_valid && (!bus.lsu_valid || rr_last == SRC_LSU)) begin
      alu_ready = 1'b1;
    end else if (bus.lsu_valid) begin
      lsu_ready = 1'b1;
    end
  end

  assign alu_xfer    = bus.alu_valid && alu_ready;
  assign lsu_xfer    = bus.lsu_valid && lsu_ready;
  assign issue_ready = !busy_q[bus.issue_rd];
  assign issue_xfer  = bus.issue_valid && issue_ready;

  // Clear on commit first so a same-edge issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_addr_q] = 1'b0;
    end
    if (issue_xfer && bus.issue_rd != '0) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last   <= SRC_LSU;
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      busy_q  <= busy_d;
      wr_en_q <= 1'b0;
      // A result for x0 is consumed but never reaches the write port.
      if (alu_xfer) begin
        rr_last <= SRC_ALU;
        if (bus.alu_rd != '0) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= bus.alu_rd;
          wr_data_q <= bus.alu_data;
        end
      end else if (lsu_xfer) begin
        rr_last <= SRC_LSU;
        if (bus.lsu_rd != '0) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= bus.lsu_rd;
          wr_data_q <= bus.lsu_data;
        end
      end
    end
  end

  assign bus.alu_ready   = alu_ready;
  assign bus.lsu_ready   = lsu_ready;
  assign bus.issue_ready = issue_ready;
  assign bus.rs_hazard   = busy_q[bus.rs1_sel] | busy_q[bus.rs2_sel];
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - randomized and directed bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_scheduler_if bus ();

  regfile_wb_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int lit_id   = 0;

  // Reference state: what the register-file write port and scoreboard must hold.
  bit [31:0] m_busy;
  bit        m_wr_en;
  bit [4:0]  m_wr_addr;
  bit [31:0] m_wr_data;
  bit        m_last_lsu;
  bit        e_issue_ready, e_haz, e_alu, e_lsu;
  int        k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      #1;
      chk("rst_busy", bus.busy, 32'h0);
      chk("rst_wr_en", {31'b0, bus.wr_en}, 32'h0);
      chk("rst_wr_addr", {27'b0, bus.wr_addr}, 32'h0);
      chk("rst_wr_data", bus.wr_data, 32'h0);
      m_busy     = '0;
      m_wr_en    = 1'b0;
      m_wr_addr  = '0;
      m_wr_data  = '0;
      m_last_lsu = 1'b1;
    end else begin
      e_issue_ready = !m_busy[bus.issue_rd];
      e_haz         = m_busy[bus.rs1_sel] || m_busy[bus.rs2_sel];
      if (bus.alu_valid && bus.lsu_valid) begin
        e_alu = m_last_lsu;
        e_lsu = !m_last_lsu;
      end else begin
        e_alu = bus.alu_valid;
        e_lsu = bus.lsu_valid;
      end

      chk("busy", bus.busy, m_busy);
      chk("wr_en", {31'b0, bus.wr_en}, {31'b0, m_wr_en});
      if (m_wr_en) begin
        chk("wr_addr", {27'b0, bus.wr_addr}, {27'b0, m_wr_addr});
        chk("wr_data", bus.wr_data, m_wr_data);
      end
      chk("alu_ready", {31'b0, bus.alu_ready}, {31'b0, e_alu});
      chk("lsu_ready", {31'b0, bus.lsu_ready}, {31'b0, e_lsu});
      chk("issue_ready", {31'b0, bus.issue_ready}, {31'b0, e_issue_ready});
      chk("rs_hazard", {31'b0, bus.rs_hazard}, {31'b0, e_haz});

      case (lit_id)
        1: begin
          chk("s2_issue_ready", {31'b0, bus.issue_ready}, 32'h1);
          chk("s2_haz_before", {31'b0, bus.rs_hazard}, 32'h0);
        end
        2: begin
          chk("s2_busy5", {31'b0, bus.busy[5]}, 32'h1);
          chk("s2_alu_ready", {31'b0, bus.alu_ready}, 32'h1);
          chk("s2_haz_pending", {31'b0, bus.rs_hazard}, 32'h1);
        end
        3: begin
          chk("s2_wr_en", {31'b0, bus.wr_en}, 32'h1);
          chk("s2_wr_addr", {27'b0, bus.wr_addr}, 32'd5);
          chk("s2_wr_data", bus.wr_data, 32'hDEADBEEF);
          chk("s2_haz_commit", {31'b0, bus.rs_hazard}, 32'h1);
        end
        4: begin
          chk("s2_haz_after", {31'b0, bus.rs_hazard}, 32'h0);
          chk("s2_busy_after", bus.busy, 32'h0);
        end
        10: begin
          chk("s1_busy9", {31'b0, bus.busy[9]}, 32'h1);
          chk("s1_wr_en", {31'b0, bus.wr_en}, 32'h1);
        end
        30, 31, 32, 33: begin
          k = lit_id - 30;
          chk("s3_alu_grant", {31'b0, bus.alu_ready}, (k % 2 == 0) ? 32'h1 : 32'h0);
          chk("s3_lsu_grant", {31'b0, bus.lsu_ready}, (k % 2 == 1) ? 32'h1 : 32'h0);
          if (k >= 1) begin
            chk("s3_wr_en", {31'b0, bus.wr_en}, 32'h1);
            chk("s3_wr_data", bus.wr_data,
                ((k - 1) % 2 == 0) ? 32'hA000_0000 + k - 1 : 32'hB000_0000 + k - 1);
          end
        end
        34: begin
          chk("s3_last_wr_en", {31'b0, bus.wr_en}, 32'h1);
          chk("s3_last_addr", {27'b0, bus.wr_addr}, 32'd4);
          chk("s3_last_data", bus.wr_data, 32'hB000_0003);
        end
        40: chk("s4_alu_ready", {31'b0, bus.alu_ready}, 32'h1);
        41: begin
          chk("s4_wr_en", {31'b0, bus.wr_en}, 32'h0);
          chk("s4_busy", bus.busy, 32'h0);
        end
        50: chk("s5_issue_free", {31'b0, bus.issue_ready}, 32'h1);
        51: begin
          chk("s5_issue_waw", {31'b0, bus.issue_ready}, 32'h0);
          chk("s5_busy7", {31'b0, bus.busy[7]}, 32'h1);
        end
        52: begin
          chk("s5_wr_en", {31'b0, bus.wr_en}, 32'h1);
          chk("s5_wr_addr", {27'b0, bus.wr_addr}, 32'd7);
          chk("s5_issue_commit", {31'b0, bus.issue_ready}, 32'h0);
        end
        53: chk("s5_issue_reopen", {31'b0, bus.issue_ready}, 32'h1);
        54: chk("s5_busy7_again", {31'b0, bus.busy[7]}, 32'h1);
        61: begin
          chk("s6_wr_addr", {27'b0, bus.wr_addr}, 32'd12);
          chk("s6_issue_ready", {31'b0, bus.issue_ready}, 32'h1);
        end
        62: chk("s6_set_wins", {31'b0, bus.busy[12]}, 32'h1);
        default: ;
      endcase

      if (m_wr_en) m_busy[m_wr_addr] = 1'b0;
      if (bus.issue_valid && e_issue_ready && bus.issue_rd != 5'd0) m_busy[bus.issue_rd] = 1'b1;
      m_wr_en = 1'b0;
      if (e_alu) begin
        m_last_lsu = 1'b0;
        if (bus.alu_rd != 5'd0) begin
          m_wr_en   = 1'b1;
          m_wr_addr = bus.alu_rd;
          m_wr_data = bus.alu_data;
        end
      end else if (e_lsu) begin
        m_last_lsu = 1'b1;
        if (bus.lsu_rd != 5'd0) begin
          m_wr_en   = 1'b1;
          m_wr_addr = bus.lsu_rd;
          m_wr_data = bus.lsu_data;
        end
      end
    end
  end

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.rs1_sel     = '0;
    bus.rs2_sel     = '0;
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.lsu_valid   = 1'b0;
    bus.lsu_rd      = '0;
    bus.lsu_data    = '0;
  endtask

  task automatic cyc(input int lid);
    lit_id = lid;
    @(posedge clk);
    #1;
    lit_id = 0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.rs1_sel = 5'd5; cyc(1);
    idle(); bus.rs1_sel = 5'd5; bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF; cyc(2);
    idle(); bus.rs1_sel = 5'd5; cyc(3);
    idle(); bus.rs1_sel = 5'd5; cyc(4);

    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; cyc(0);
    idle(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'd99; cyc(0);
    idle(); lit_id = 10;
    @(negedge clk);
    #2 rst = 1'b1;
    lit_id = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hA000_0000 + i;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'hB000_0000 + i;
      cyc(30 + i);
    end
    idle(); cyc(34);

    idle(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1; cyc(40);
    idle(); cyc(41);

    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; cyc(50);
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'd77; cyc(51);
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; cyc(52);
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; cyc(53);
    idle(); cyc(54);

    idle(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'd12; cyc(60);
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd12; cyc(61);
    idle(); cyc(62);

    for (int i = 0; i < 3000; i++) begin
      idle();
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = 5'($urandom_range(0, 7));
      bus.rs1_sel     = 5'($urandom_range(0, 7));
      bus.rs2_sel     = 5'($urandom_range(0, 7));
      bus.alu_valid   = 1'($urandom_range(0, 1));
      bus.alu_rd      = 5'($urandom_range(0, 7));
      bus.alu_data    = $urandom;
      bus.lsu_valid   = 1'($urandom_range(0, 1));
      bus.lsu_rd      = 5'($urandom_range(0, 7));
      bus.lsu_data    = $urandom;
      if (i == 1500) pulse_reset();
      else cyc(0);
    end

    idle();
    repeat (3) cyc(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
